// File: rtl/mult_issue_ctrl.sv
`timescale 1ns/1ps
// Issue stage for the iterative multiplier: queues operand pairs,
// issues them one at a time, and returns products on a valid/ready port.
//
// Ports:
//   clk, resetb            clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake; in_a, in_b operands
//   mul_start/ain/bin      registered issue to the multiplier
//   mul_done/mul_yout      multiplier status and product
//   out_valid/out_ready    result handshake; out_y captured product
//   count, busy, err       occupancy, not-idle, sticky watchdog error
module mult_issue_ctrl #(
  parameter int N        = 16,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int WD_LIMIT = 40
) (
  input  logic           clk,
  input  logic           resetb,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           mul_start,
  output logic [N-1:0]   mul_ain,
  output logic [N-1:0]   mul_bin,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_yout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_y,
  output logic [AW:0]    count,
  output logic           busy,
  output logic           err
);

  localparam int WW = $clog2(WD_LIMIT + 1);
  localparam logic [AW:0]   L_DEPTH = DEPTH[AW:0];
  localparam logic [WW-1:0] L_WD    = WD_LIMIT[WW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [2*N-1:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WW-1:0]    r_wd;
  logic             r_start;
  logic [N-1:0]     r_ain;
  logic [N-1:0]     r_bin;
  logic             r_out_valid;
  logic [2*N-1:0]   r_out_y;
  logic             r_err;

  logic             w_in_ready;
  logic             w_push;
  logic             w_issue;
  logic [2*N-1:0]   w_head;
  logic [WW-1:0]    w_wd_next;

  assign w_in_ready = (r_count < L_DEPTH);
  assign w_push     = in_valid && w_in_ready;
  // One result in flight: never issue while a product awaits pickup.
  assign w_issue    = (r_state == S_IDLE) && (r_count != '0)
                      && mul_done && !r_out_valid;
  assign w_head     = r_mem[r_rptr];
  assign w_wd_next  = r_wd + WW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_issue) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_issue})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= S_IDLE;
      r_wd        <= '0;
      r_start     <= 1'b0;
      r_ain       <= '0;
      r_bin       <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_start <= 1'b1;
            r_ain   <= w_head[2*N-1:N];
            r_bin   <= w_head[N-1:0];
            r_wd    <= '0;
            r_state <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          // r_start high marks the first cycle; done then is stale.
          r_start <= 1'b0;
          r_wd    <= w_wd_next;
          if (w_wd_next == L_WD) begin
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end else if (!r_start && !mul_done) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          r_wd <= w_wd_next;
          if (mul_done) begin
            r_out_y     <= mul_yout;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_wd_next == L_WD) begin
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_start <= 1'b0;
          if (mul_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign mul_start = r_start;
  assign mul_ain   = r_ain;
  assign mul_bin   = r_bin;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
`timescale 1ns/1ps
// Bench for mult_issue_ctrl: behavioural multiplier plus a
// queue of expected products in push order.
module tb_mult_issue_ctrl;

  localparam int N  = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          mul_start;
  logic [N-1:0]  mul_ain;
  logic [N-1:0]  mul_bin;
  logic          mul_done;
  logic [31:0]   mul_yout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_y;
  logic [AW:0]   count;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mult_issue_ctrl dut (
    .clk       (clk),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_ain   (mul_ain),
    .mul_bin   (mul_bin),
    .mul_done  (mul_done),
    .mul_yout  (mul_yout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .count     (count),
    .busy      (busy),
    .err       (err)
  );

  function automatic int kof(logic [15:0] b);
    int k = 0;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Multiplier model: done drops the edge after start, rises k+1 edges later.
  logic [N-1:0] m_a, m_b;
  int           m_cnt;
  logic         m_busy;
  bit           hang_next = 0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mul_done <= 1'b1;
      mul_yout <= '0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_a      <= '0;
      m_b      <= '0;
    end else if (mul_start) begin
      m_a      <= mul_ain;
      m_b      <= mul_bin;
      mul_done <= 1'b0;
      m_busy   <= 1'b1;
      m_cnt    <= hang_next ? 50 : kof(mul_bin);
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mul_done <= 1'b1;
        mul_yout <= 32'(m_a) * 32'(m_b);
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int   n_start = 0;
  int   n_wide = 0;
  logic prev_s = 1'b0;
  always @(posedge clk) begin
    if (mul_start) n_start++;
    if (mul_start && prev_s) n_wide++;
    prev_s = mul_start;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  bit          last_push;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes seen before the edge, then advance.
  task automatic step();
    bit push, acc;
    push = in_valid && in_ready;
    acc  = out_valid && out_ready;
    if (acc) begin
      chk("result_expected", 64'(q.size() != 0), 1);
      if (q.size() != 0) chk("out_y", out_y, q.pop_front());
    end
    if (push) q.push_back(32'(in_a) * 32'(in_b));
    last_push = push;
    @(posedge clk); #1;
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (last_push) break;
    end
    chk("send_accepted", 64'(last_push), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (q.size() == 0 && !busy && !out_valid && count == 0) break;
      step();
    end
    chk("drain_q", 64'(q.size()), 0);
    chk("drain_count", 64'(count), 0);
  endtask

  task automatic lat_op(logic [15:0] a, logic [15:0] b, int exp_lat);
    int s0, n;
    s0 = n_start;
    out_ready = 1'b1;
    in_a = a; in_b = b; in_valid = 1'b1;
    chk("lat_in_ready", 64'(in_ready), 1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("lat_y", out_y, 32'(a) * 32'(b));
    step();
    chk("lat_ov_fall", 64'(out_valid), 0);
    chk("lat_count", 64'(count), 0);
    chk("one_start", 64'(n_start - s0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bit ov;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    va = '{16'h0003, 16'hFFFF, 16'h1234, 16'hABCD, 16'h0007, 16'h0100};
    vb = '{16'h0005, 16'hFFFF, 16'h0001, 16'h0000, 16'h0009, 16'h0200};

    #12;
    chk("rst_count", 64'(count), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_start", 64'(mul_start), 0);
    chk("rst_ain", 64'(mul_ain), 0);
    chk("rst_bin", 64'(mul_bin), 0);
    chk("rst_ov", 64'(out_valid), 0);
    chk("rst_y", 64'(out_y), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;

    // Latency: out_valid at push + 4 + k.
    lat_op(16'd3, 16'd5, 7);
    chk("prod_15", 64'(out_y), 32'h0000000F);
    lat_op(16'h1234, 16'h0000, 4);
    lat_op(16'h1234, 16'h0001, 5);
    chk("prod_1234", 64'(out_y), 32'h00001234);
    lat_op(16'hFFFF, 16'hFFFF, 20);
    chk("prod_max", 64'(out_y), 32'hFFFE0001);

    // Backpressure: one result parked, four queued, sixth refused.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(va[i], vb[i]);
    in_a = va[5]; in_b = vb[5]; in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (last_push) n++;
    end
    chk("full_no_push", 64'(n), 0);
    chk("full_count", 64'(count), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_ov", 64'(out_valid), 1);
    chk("full_y_head", 64'(out_y), 32'h0000000F);
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (last_push) break;
    end
    chk("full_sixth", 64'(last_push), 1);
    in_valid = 1'b0;
    drain();

    // Push on the same edge as an issue with two queued.
    out_ready = 1'b0;
    send(16'd11, 16'd13);
    send(16'd21, 16'd2);
    send(16'd31, 16'd3);
    for (int i = 0; i < 40 && !out_valid; i++) step();
    chk("sim_ov", 64'(out_valid), 1);
    chk("sim_count_pre", 64'(count), 2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_a = 16'd41; in_b = 16'd4; in_valid = 1'b1;
    chk("sim_idle", 64'(busy), 0);
    step();
    in_valid = 1'b0;
    chk("sim_pushed", 64'(last_push), 1);
    chk("sim_issued", 64'(mul_start), 1);
    chk("sim_count", 64'(count), 2);
    drain();

    // Watchdog: multiplier hangs after start.
    out_ready = 1'b1;
    hang_next = 1;
    in_a = 16'd5; in_b = 16'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    send(16'd7, 16'd8);
    chk("wd_issue", 64'(mul_start), 1);
    n = 0;
    ov = 0;
    while (!err && n < 100) begin
      step();
      n++;
      if (n == 1) hang_next = 0;
      ov |= out_valid;
    end
    chk("wd_cycles", 64'(n), 40);
    chk("wd_no_ov", 64'(ov), 0);
    chk("wd_hold", 64'(busy), 1);
    if (q.size() != 0) void'(q.pop_front());
    drain();
    chk("wd_err_sticky", 64'(err), 1);

    // Reset while waiting on a long op with three queued.
    out_ready = 1'b0;
    send(16'h0055, 16'hFFFF);
    send(16'd1, 16'd2);
    send(16'd3, 16'd4);
    send(16'd5, 16'd6);
    step();
    chk("mid_busy", 64'(busy), 1);
    chk("mid_count", 64'(count), 3);
    resetb = 1'b0;
    #1;
    chk("mrst_count", 64'(count), 0);
    chk("mrst_start", 64'(mul_start), 0);
    chk("mrst_ain", 64'(mul_ain), 0);
    chk("mrst_bin", 64'(mul_bin), 0);
    chk("mrst_ov", 64'(out_valid), 0);
    chk("mrst_y", 64'(out_y), 0);
    chk("mrst_err", 64'(err), 0);
    chk("mrst_busy", 64'(busy), 0);
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    resetb = 1'b1;
    out_ready = 1'b1;
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      ov |= out_valid;
    end
    chk("post_rst_no_ov", 64'(ov), 0);
    chk("post_rst_count", 64'(count), 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_a = 16'($urandom);
        in_b = 16'($urandom) >> $urandom_range(0, 15);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("start_width", 64'(n_wide), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
